// File: rtl/eth_phy_10g_serdes_src.sv
`default_nettype none
// ============================================================================
// Module   : eth_phy_10g_serdes_src
// Purpose  : 66b SerDes stimulus source for a 10GBASE-R PHY receive path.
//            Presents one 66b block per cycle, or an idle block when no block
//            is offered. Blocks pass through a two-deep history window. The
//            output word is cut from that window at a programmable bit
//            offset. Optional sync-header error bursts can be injected.
// Ports    : rx_clk            - single clock, rising edge
//            rx_rst            - synchronous active-high reset
//            blk_data/blk_hdr  - payload/sync header of the next block
//            blk_valid         - block input valid (else idle block sent)
//            serdes_rx_bitslip - slip request; each rising edge = +1 bit
//            inj_hdr_err       - pulse starting a header-error burst
//            inj_count         - burst length in words (0 = ignore pulse)
//            serdes_rx_data    - aligned data word to PHY RX
//            serdes_rx_hdr     - aligned header to PHY RX (forced 2'b11 in burst)
//            slip_count        - current bit offset, 0..65
//            inj_busy          - header-error burst in progress
// Config   : define ETH_SERDES_SRC_BITSLIP_EN to enable bitslip handling.
//            When it is undefined the offset stays at INIT_SLIP.
// Revision : 1.0 - initial release
// ============================================================================
module eth_phy_10g_serdes_src #(
  parameter int DATA_WIDTH = 64,
  parameter int HDR_WIDTH  = 2,
  parameter int INIT_SLIP  = 0
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst,
  input  logic [DATA_WIDTH-1:0] blk_data,
  input  logic [HDR_WIDTH-1:0]  blk_hdr,
  input  logic                  blk_valid,
  input  logic                  serdes_rx_bitslip,
  input  logic                  inj_hdr_err,
  input  logic [6:0]            inj_count,
  output logic [DATA_WIDTH-1:0] serdes_rx_data,
  output logic [HDR_WIDTH-1:0]  serdes_rx_hdr,
  output logic [6:0]            slip_count,
  output logic                  inj_busy
);

  localparam int               BLK_W       = DATA_WIDTH + HDR_WIDTH;
  localparam logic [BLK_W-1:0] c_IDLE_BLK  = {DATA_WIDTH'(64'h1E), HDR_WIDTH'(2'b10)};
  localparam logic [6:0]       c_INIT_SLIP = 7'(INIT_SLIP);
  localparam logic [6:0]       c_MAX_SLIP  = 7'(BLK_W - 1);

  logic [BLK_W-1:0]   w_blk;
  logic [BLK_W-1:0]   r_cur;
  logic [BLK_W-1:0]   r_prev;
  logic [2*BLK_W-1:0] w_win;
  logic [BLK_W-1:0]   w_aligned;
  logic [6:0]         r_slip;
  logic [6:0]         r_err_left;
  logic               w_inj_load;
  logic               w_force;
  logic [DATA_WIDTH-1:0] r_data;
  logic [HDR_WIDTH-1:0]  r_hdr;

  // Block entering the window this cycle: header occupies the low bits.
  assign w_blk = blk_valid ? {blk_data, blk_hdr} : c_IDLE_BLK;

  // Older block sits in the low half so that a slip of k pulls the upper
  // k bits of the output word from the newer block.
  assign w_win     = {r_cur, r_prev};
  assign w_aligned = w_win[r_slip +: BLK_W];

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      r_cur  <= c_IDLE_BLK;
      r_prev <= c_IDLE_BLK;
    end else begin
      r_cur  <= w_blk;
      r_prev <= r_cur;
    end
  end

`ifdef ETH_SERDES_SRC_BITSLIP_EN
  logic r_bs_d;
  logic w_bs_rise;

  // Only a rising edge counts, so a request held high slips exactly once.
  assign w_bs_rise = serdes_rx_bitslip & ~r_bs_d;

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      r_bs_d <= 1'b0;
      r_slip <= c_INIT_SLIP;
    end else begin
      r_bs_d <= serdes_rx_bitslip;
      if (w_bs_rise) begin
        r_slip <= (r_slip == c_MAX_SLIP) ? 7'd0 : r_slip + 7'd1;
      end
    end
  end
`else
  logic w_unused_bitslip;

  assign w_unused_bitslip = serdes_rx_bitslip;

  always_ff @(posedge rx_clk) begin
    r_slip <= c_INIT_SLIP;
  end
`endif

  // A new non-zero pulse always reloads the remaining count; a word is
  // forced whenever the count is non-zero before the edge, including the
  // edge that reloads it.
  assign w_inj_load = inj_hdr_err && (inj_count != 7'd0);
  assign w_force    = (r_err_left != 7'd0);

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      r_err_left <= 7'd0;
    end else if (w_inj_load) begin
      r_err_left <= inj_count;
    end else if (w_force) begin
      r_err_left <= r_err_left - 7'd1;
    end
  end

  // Forcing happens after alignment so the injected header is independent
  // of the current slip.
  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      r_data <= '0;
      r_hdr  <= '0;
    end else begin
      r_data <= w_aligned[BLK_W-1:HDR_WIDTH];
      r_hdr  <= w_force ? {HDR_WIDTH{1'b1}} : w_aligned[HDR_WIDTH-1:0];
    end
  end

  assign serdes_rx_data = r_data;
  assign serdes_rx_hdr  = r_hdr;
  assign slip_count     = r_slip;
  assign inj_busy       = w_force;

endmodule
`default_nettype wire

// File: tb/tb_eth_phy_10g_serdes_src.sv
`default_nettype none
// ============================================================================
// Module   : tb_eth_phy_10g_serdes_src
// Purpose  : Self-checking bench for eth_phy_10g_serdes_src. A block-history
//            reference model predicts every registered output word, the
//            offset and the burst flag. Directed scenarios add fixed checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_eth_phy_10g_serdes_src;

  localparam int INIT_SLIP = 0;
`ifdef ETH_SERDES_SRC_BITSLIP_EN
  localparam bit BITSLIP_EN = 1'b1;
`else
  localparam bit BITSLIP_EN = 1'b0;
`endif
  localparam logic [65:0] IDLE = {64'h1E, 2'b10};
  localparam int HMAX = 8192;

  logic        rx_clk = 1'b0;
  logic        rx_rst = 1'b1;
  logic [63:0] blk_data = '0;
  logic [1:0]  blk_hdr = '0;
  logic        blk_valid = 1'b0;
  logic        serdes_rx_bitslip = 1'b0;
  logic        inj_hdr_err = 1'b0;
  logic [6:0]  inj_count = '0;
  logic [63:0] serdes_rx_data;
  logic [1:0]  serdes_rx_hdr;
  logic [6:0]  slip_count;
  logic        inj_busy;

  eth_phy_10g_serdes_src #(
    .DATA_WIDTH(64), .HDR_WIDTH(2), .INIT_SLIP(INIT_SLIP)
  ) dut (
    .rx_clk(rx_clk), .rx_rst(rx_rst),
    .blk_data(blk_data), .blk_hdr(blk_hdr), .blk_valid(blk_valid),
    .serdes_rx_bitslip(serdes_rx_bitslip),
    .inj_hdr_err(inj_hdr_err), .inj_count(inj_count),
    .serdes_rx_data(serdes_rx_data), .serdes_rx_hdr(serdes_rx_hdr),
    .slip_count(slip_count), .inj_busy(inj_busy)
  );

  always #5 rx_clk = ~rx_clk;

  // Reference model: hist[k] is the block sampled at edge k; forced_at[k]
  // marks edges whose output header must read 2'b11.
  logic [65:0] hist [0:HMAX-1];
  bit          forced_at [0:HMAX-1];
  int          e = 2;
  int          m_slip = INIT_SLIP;
  bit          m_bs_prev = 1'b0;
  logic [63:0] exp_data;
  logic [1:0]  exp_hdr;
  logic [6:0]  exp_slip;
  logic        exp_busy;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic tick();
    logic [131:0] win;
    logic [65:0]  word;
    @(posedge rx_clk);
    e++;
    if (rx_rst) begin
      hist[e]   = IDLE;
      hist[e-1] = IDLE;
      for (int j = e; j <= e + 130; j++) forced_at[j] = 1'b0;
      m_slip    = INIT_SLIP;
      m_bs_prev = 1'b0;
      exp_data  = '0;
      exp_hdr   = '0;
    end else begin
      hist[e]  = blk_valid ? {blk_data, blk_hdr} : IDLE;
      win      = {hist[e-1], hist[e-2]};
      word     = 66'(win >> m_slip);
      exp_data = word[65:2];
      exp_hdr  = forced_at[e] ? 2'b11 : word[1:0];
      if (inj_hdr_err && inj_count != 7'd0)
        for (int j = 1; j <= 130; j++) forced_at[e+j] = (j <= int'(inj_count));
      if (BITSLIP_EN && serdes_rx_bitslip && !m_bs_prev) m_slip = (m_slip + 1) % 66;
      m_bs_prev = serdes_rx_bitslip;
    end
    exp_slip = 7'(m_slip);
    exp_busy = 1'b0;
    for (int j = 1; j <= 130; j++) if (forced_at[e+j]) exp_busy = 1'b1;
    #1;
  endtask

  task automatic rand_block();
    blk_valid = 1'b1;
    blk_data  = {$urandom, $urandom};
    blk_hdr   = 2'($urandom_range(0, 3));
  endtask

  task automatic test_reset();
    rx_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if ({serdes_rx_data, serdes_rx_hdr, slip_count, inj_busy} !==
          {64'h0, 2'b00, 7'(INIT_SLIP), 1'b0}) begin
        n_err++;
        $display("FAIL reset: got data=%h hdr=%b slip=%0d busy=%b, expected zero/INIT_SLIP/0",
                 serdes_rx_data, serdes_rx_hdr, slip_count, inj_busy);
      end
    end
    rx_rst = 1'b0;
  endtask

  task automatic test_idle();
    blk_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_vec++;
      if ({serdes_rx_data, serdes_rx_hdr, slip_count, inj_busy} !==
          {exp_data, exp_hdr, exp_slip, exp_busy}) begin
        n_err++;
        $display("FAIL idle_model edge %0d: got %h/%b/%0d/%b expected %h/%b/%0d/%b", i,
                 serdes_rx_data, serdes_rx_hdr, slip_count, inj_busy,
                 exp_data, exp_hdr, exp_slip, exp_busy);
      end
      if (i >= 3) begin
        n_vec++;
        if ({serdes_rx_data, serdes_rx_hdr} !== {64'h1E, 2'b10}) begin
          n_err++;
          $display("FAIL idle_word edge %0d: got %h/%b expected 000000000000001e/10",
                   i, serdes_rx_data, serdes_rx_hdr);
        end
      end
    end
  endtask

  task automatic test_passthrough();
    blk_valid = 1'b1;
    blk_data  = 64'h5555555555555555;
    blk_hdr   = 2'b01;
    tick();
    rand_block();
    tick();
    tick();
    n_vec++;
    if ({serdes_rx_data, serdes_rx_hdr} !== {64'h5555555555555555, 2'b01}) begin
      n_err++;
      $display("FAIL passthrough: got %h/%b expected 5555555555555555/01",
               serdes_rx_data, serdes_rx_hdr);
    end
    for (int i = 0; i < 8; i++) begin
      rand_block();
      tick();
      n_vec++;
      if ({serdes_rx_data, serdes_rx_hdr, slip_count, inj_busy} !==
          {exp_data, exp_hdr, exp_slip, exp_busy}) begin
        n_err++;
        $display("FAIL passthrough_rand %0d: got %h/%b expected %h/%b", i,
                 serdes_rx_data, serdes_rx_hdr, exp_data, exp_hdr);
      end
    end
  endtask

  task automatic test_bitslip_hold();
    rx_rst = 1'b1; tick(); rx_rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_block();
      serdes_rx_bitslip = (i >= 2 && i < 5);
      tick();
      n_vec++;
      if ({serdes_rx_data, serdes_rx_hdr, slip_count, inj_busy} !==
          {exp_data, exp_hdr, exp_slip, exp_busy}) begin
        n_err++;
        $display("FAIL bitslip_hold cyc %0d: got %h/%b slip=%0d expected %h/%b slip=%0d", i,
                 serdes_rx_data, serdes_rx_hdr, slip_count, exp_data, exp_hdr, exp_slip);
      end
    end
    serdes_rx_bitslip = 1'b0;
    n_vec++;
    if (slip_count !== (BITSLIP_EN ? 7'd1 : 7'(INIT_SLIP))) begin
      n_err++;
      $display("FAIL bitslip_once: got slip=%0d expected %0d", slip_count,
               BITSLIP_EN ? 1 : INIT_SLIP);
    end
  endtask

  task automatic test_bitslip_wrap();
    rx_rst = 1'b1; tick(); rx_rst = 1'b0;
    for (int p = 0; p < 66; p++) begin
      for (int c = 0; c < 9; c++) begin
        rand_block();
        serdes_rx_bitslip = (c == 0);
        tick();
        n_vec++;
        if ({serdes_rx_data, serdes_rx_hdr, slip_count, inj_busy} !==
            {exp_data, exp_hdr, exp_slip, exp_busy}) begin
          n_err++;
          $display("FAIL bitslip_wrap p%0d c%0d: got %h/%b slip=%0d expected %h/%b slip=%0d",
                   p, c, serdes_rx_data, serdes_rx_hdr, slip_count, exp_data, exp_hdr, exp_slip);
        end
      end
`ifdef ETH_SERDES_SRC_BITSLIP_EN
      if (p == 64) begin
        n_vec++;
        if (slip_count !== 7'd65) begin
          n_err++;
          $display("FAIL bitslip_max: got slip=%0d expected 65", slip_count);
        end
      end
`endif
    end
    serdes_rx_bitslip = 1'b0;
    n_vec++;
    if (slip_count !== 7'd0) begin
      n_err++;
      $display("FAIL bitslip_wrap_end: got slip=%0d expected 0", slip_count);
    end
  endtask

  task automatic test_hdr_burst();
    int forced;
    rx_rst = 1'b1; tick(); rx_rst = 1'b0;
    forced = 0;
    for (int i = 0; i < 12; i++) begin
      blk_valid = 1'b1;
      blk_data  = {$urandom, $urandom};
      blk_hdr   = 2'b01;
      inj_hdr_err = (i == 3 || i == 5);
      inj_count   = (i == 3) ? 7'd5 : 7'd2;
      tick();
      if (serdes_rx_hdr == 2'b11) forced++;
      n_vec++;
      if ({serdes_rx_data, serdes_rx_hdr, slip_count, inj_busy} !==
          {exp_data, exp_hdr, exp_slip, exp_busy}) begin
        n_err++;
        $display("FAIL hdr_burst cyc %0d: got %h/%b busy=%b expected %h/%b busy=%b", i,
                 serdes_rx_data, serdes_rx_hdr, inj_busy, exp_data, exp_hdr, exp_busy);
      end
    end
    inj_hdr_err = 1'b0;
    n_vec++;
    if (forced !== 4 || inj_busy !== 1'b0) begin
      n_err++;
      $display("FAIL hdr_burst_count: got %0d forced words busy=%b expected 4 busy=0",
               forced, inj_busy);
    end
  endtask

  task automatic test_reset_mid();
    rx_rst = 1'b1; tick(); rx_rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      rand_block();
      serdes_rx_bitslip = (i % 2 == 0);
      tick();
    end
    serdes_rx_bitslip = 1'b0;
    inj_hdr_err = 1'b1; inj_count = 7'd5;
    tick();
    inj_hdr_err = 1'b0;
    tick();
    tick();
    n_vec++;
    if ({slip_count, inj_busy} !== {(BITSLIP_EN ? 7'd10 : 7'(INIT_SLIP)), 1'b1}) begin
      n_err++;
      $display("FAIL pre_reset: got slip=%0d busy=%b expected slip=%0d busy=1",
               slip_count, inj_busy, BITSLIP_EN ? 10 : INIT_SLIP);
    end
    rx_rst = 1'b1;
    tick();
    rx_rst = 1'b0;
    n_vec++;
    if ({serdes_rx_data, serdes_rx_hdr, slip_count, inj_busy} !==
        {64'h0, 2'b00, 7'(INIT_SLIP), 1'b0}) begin
      n_err++;
      $display("FAIL reset_mid: got %h/%b slip=%0d busy=%b expected 0/00 slip=%0d busy=0",
               serdes_rx_data, serdes_rx_hdr, slip_count, inj_busy, INIT_SLIP);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1200; i++) begin
      blk_valid = ($urandom_range(0, 3) != 0);
      blk_data  = {$urandom, $urandom};
      blk_hdr   = 2'($urandom_range(0, 3));
      serdes_rx_bitslip = ($urandom_range(0, 5) == 0);
      inj_hdr_err = ($urandom_range(0, 19) == 0);
      inj_count   = 7'($urandom_range(0, 12));
      rx_rst      = ($urandom_range(0, 199) == 0);
      tick();
      n_vec++;
      if ({serdes_rx_data, serdes_rx_hdr, slip_count, inj_busy} !==
          {exp_data, exp_hdr, exp_slip, exp_busy}) begin
        n_err++;
        $display("FAIL random cyc %0d: got %h/%b slip=%0d busy=%b expected %h/%b slip=%0d busy=%b",
                 i, serdes_rx_data, serdes_rx_hdr, slip_count, inj_busy,
                 exp_data, exp_hdr, exp_slip, exp_busy);
      end
    end
    rx_rst = 1'b0; serdes_rx_bitslip = 1'b0; inj_hdr_err = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < HMAX; i++) hist[i] = IDLE;
    @(negedge rx_clk);
    test_reset();
    test_idle();
    test_passthrough();
    test_bitslip_hold();
    test_bitslip_wrap();
    test_hdr_burst();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
